instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 23 ++
 rtl/pc_next.sv | 29 ++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit: register width, default
// reset PC and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
`ifndef REGWIDTH
`define REGWIDTH 32
`endif

package instr_fetch_pkg;

    localparam int REGWIDTH = `REGWIDTH;

    localparam logic [REGWIDTH-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // one cycle after reset before the first fetch
        ST_REQ   = 2'd1,   // request outstanding to instruction memory
        ST_VALID = 2'd2,   // instruction held for the decoder
        ST_HALT  = 2'd3    // ECALL retired; only reset leaves this state
    } fetch_state_e;

endpackage

// File: rtl/pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection for the fetch unit.
//   pc_i           current fetch PC
//   redirect_i     branch/jump taken
//   redirect_pc_i  redirect target (low two bits are cleared)
//   pc_next_o      redirect ? aligned target : pc_i + 4 (wraps modulo 2^XLEN)
// -----------------------------------------------------------------------------
module pc_next
    import instr_fetch_pkg::*;
#(
    parameter int XLEN = REGWIDTH
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_next_o
);

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_tgt;

    // Plain XLEN-bit add: the carry out is dropped, so the top of the
    // address space wraps to zero.
    assign pc_seq    = pc_i + XLEN'(4);
    assign pc_tgt    = redirect_pc_i & ~XLEN'(3);
    assign pc_next_o = redirect_i ? pc_tgt : pc_seq;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Single-outstanding-request instruction fetch unit. Fetches one word at a
// time from instruction memory, holds it for the decode controller, follows
// redirects (discarding in-flight responses) and halts permanently on ECALL.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   imem_req / imem_addr    fetch request and word-aligned address
//   imem_ack / imem_rdata   memory response, data valid with ack
//   inst / pc / inst_valid  held instruction, its address, valid flag
//   inst_ready              decoder consumes the held instruction this cycle
//   redirect / redirect_pc  taken branch/jump and its target
//   stop                    ECALL decoded for the held instruction
//   halted                  fetch permanently stopped
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN     = REGWIDTH,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stop,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            kill_q, kill_d;   // outstanding response belongs to a stale PC
    logic [XLEN-1:0] pc_nxt;

    pc_next #(
        .XLEN(XLEN)
    ) u_pc_next (
        .pc_i         (pc_q),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .pc_next_o    (pc_nxt)
    );

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values, independent of statement order. The held
    // instruction is a single register, so it is reset along with the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        kill_d     = kill_q;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // Retarget. If the old response arrives in this same
                    // cycle it is dropped here and nothing remains in flight,
                    // otherwise the next ack must be discarded.
                    pc_d   = pc_nxt;
                    kill_d = !imem_ack;
                end else if (imem_ack) begin
                    if (kill_q) begin
                        // Stale response: drop it and re-request at pc_q,
                        // which already holds the redirect target.
                        kill_d = 1'b0;
                    end else begin
                        inst_d  = imem_rdata;
                        state_d = ST_VALID;
                    end
                end
            end

            ST_VALID: begin
                inst_valid = 1'b1;
                if (inst_ready && stop) begin
                    state_d = ST_HALT;
                end else if (inst_ready || redirect) begin
                    // Consumed (sequential or taken), or dropped by a redirect
                    // while the decoder stalls; pc_nxt covers both cases.
                    pc_d    = pc_nxt;
                    state_d = ST_REQ;
                end
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A behavioural memory answers requests
// after a programmable latency; every instruction the decoder is expected to
// consume is queued up front and compared when the handshake is seen.
// A second instance with RESET_PC at the top of memory covers PC wrap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_instr_fetch;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] STRAY_DATA = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            inst_valid;
    logic            inst_ready;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stop;
    logic            halted;

    // Wrap instance: memory always acks, decoder always ready.
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_inst;
    logic [XLEN-1:0] w_pc;
    logic            w_valid;
    logic            w_halted;
    logic            w_one;
    logic            w_zero;
    logic [XLEN-1:0] w_zero_bus;
    assign w_one      = 1'b1;
    assign w_zero     = 1'b0;
    assign w_zero_bus = '0;

    // Memory model state
    int              mem_lat = 0;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_busy;
    logic [XLEN-1:0] mem_addr;
    int              mem_wait;
    logic            stray_ack;

    assign imem_ack   = mem_ack | stray_ack;
    assign imem_rdata = stray_ack ? STRAY_DATA : mem_rdata;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    instr_fetch u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stop       (stop),
        .halted     (halted)
    );

    instr_fetch #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ack   (w_one),
        .imem_rdata (w_zero_bus),
        .inst       (w_inst),
        .pc         (w_pc),
        .inst_valid (w_valid),
        .inst_ready (w_one),
        .redirect   (w_zero),
        .redirect_pc(w_zero_bus),
        .stop       (w_zero),
        .halted     (w_halted)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0] ^ 16'h5A5A};
    endfunction

    // Memory: latches the address when a request is first seen, acks
    // mem_lat cycles later with that address's word, one transaction at a time.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        mem_busy  = 1'b0;
        mem_addr  = '0;
        mem_wait  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_ack   = 1'b0;
                mem_busy  = 1'b0;
                mem_rdata = '0;
            end else begin
                if (mem_ack) begin
                    mem_ack   = 1'b0;
                    mem_busy  = 1'b0;
                    mem_rdata = '0;
                end
                if (!mem_busy && imem_req) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_addr;
                    mem_wait = mem_lat;
                end
                if (mem_busy) begin
                    if (mem_wait == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_word(mem_addr);
                    end else begin
                        mem_wait = mem_wait - 1;
                    end
                end
            end
        end
    end

    // Scoreboard: every consumed instruction must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: consumed pc=%h inst=%h, nothing expected", pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc !== e.pc || inst !== e.inst) begin
                    errors++;
                    $display("FAIL sb_consume: got pc=%h inst=%h, expected pc=%h inst=%h",
                             pc, inst, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [XLEN-1:0] a);
        exp_q.push_back('{pc: a, inst: mem_word(a)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stop        = 1'b0;
        stray_ack   = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d fetches still expected after %0d cycles",
                     tag, exp_q.size(), n);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!inst_valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL %s_valid_timeout: inst_valid=%b after %0d cycles, expected 1",
                     tag, inst_valid, n);
        end
    endtask

    // Reset values, async abort mid-request, stray ack around release.
    task automatic test_reset();
        int n;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 ||
            imem_addr !== 32'h0 || pc !== 32'h0 || inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b halted=%b addr=%h pc=%h inst=%h, expected 0 0 0 0 0 0",
                     imem_req, inst_valid, halted, imem_addr, pc, inst);
        end
        do_reset();
        mem_lat = 3;
        n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: req=%b valid=%b addr=%h pc=%h, expected 0 0 0 0",
                     imem_req, inst_valid, imem_addr, pc);
        end
        stray_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        stray_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_late_ack: valid=%b inst=%h req=%b addr=%h, expected 0 0 1 0",
                     inst_valid, inst, imem_req, imem_addr);
        end
    endtask

    // 1-cycle memory, decoder always ready: 0,4,8,12 in order.
    task automatic test_sequential();
        do_reset();
        mem_lat    = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_fetch(XLEN'(4 * i));
        @(negedge clk);   // cycle 2 after release: request out
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL seq_first_req: valid=%b req=%b addr=%h, expected 0 1 0",
                     inst_valid, imem_req, imem_addr);
        end
        @(negedge clk);   // cycle 3 after release: first instruction held
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL seq_first_valid: inst_valid=%b, expected 1", inst_valid);
        end
        wait_drain("seq", 40);
        inst_ready = 1'b0;
    endtask

    // 3-cycle memory: address held during the wait, data captured on ack,
    // stray ack while holding is ignored.
    task automatic test_slow_mem();
        int              waited = 0;
        int              n      = 0;
        logic [XLEN-1:0] ack_data = '0;
        logic            addr_moved = 1'b0;
        do_reset();
        mem_lat = 3;
        while (!inst_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (imem_req) begin
                if (imem_addr !== 32'h0) addr_moved = 1'b1;
                if (imem_ack) ack_data = imem_rdata;
                else waited++;
            end
        end
        checks++;
        if (addr_moved) begin
            errors++;
            $display("FAIL slow_addr_stable: imem_addr changed during wait, expected 00000000");
        end
        checks++;
        if (waited != 3) begin
            errors++;
            $display("FAIL slow_wait: %0d cycles without ack, expected 3", waited);
        end
        checks++;
        if (inst !== mem_word(32'h0) || inst !== ack_data || pc !== 32'h0) begin
            errors++;
            $display("FAIL slow_inst: inst=%h pc=%h ack_data=%h, expected inst=%h pc=0",
                     inst, pc, ack_data, mem_word(32'h0));
        end
        tick();
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (inst !== mem_word(32'h0) || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL slow_stray_ack: inst=%h valid=%b, expected %h 1",
                     inst, inst_valid, mem_word(32'h0));
        end
        expect_fetch(32'h0);
        inst_ready = 1'b1;
        wait_drain("slow", 20);
        inst_ready = 1'b0;
    endtask

    // Redirect while the decoder stalls: held instruction dropped.
    task automatic test_redirect_valid();
        do_reset();
        mem_lat = 0;
        wait_valid("rv", 10);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rv_retarget: req=%b addr=%h valid=%b, expected 1 00000100 0",
                     imem_req, imem_addr, inst_valid);
        end
        expect_fetch(32'h0000_0100);
        inst_ready = 1'b1;
        wait_drain("rv", 20);
        inst_ready = 1'b0;
    endtask

    // Redirect together with consumption: next fetch at the aligned target.
    task automatic test_redirect_taken();
        do_reset();
        mem_lat    = 0;
        inst_ready = 1'b1;
        expect_fetch(32'h0);
        expect_fetch(32'h0000_0300);
        expect_fetch(32'h0000_0304);
        wait_valid("rt", 10);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0302;
        tick();
        redirect = 1'b0;
        wait_drain("rt", 30);
        inst_ready = 1'b0;
    endtask

    // Redirect while a request is outstanding at 0x8, then a second redirect.
    task automatic test_redirect_req();
        int   n       = 0;
        logic seen_8  = 1'b0;
        do_reset();
        mem_lat    = 2;
        inst_ready = 1'b1;
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        while (!(imem_req && imem_addr == 32'h8) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!(imem_req && imem_addr == 32'h8)) begin
            errors++;
            $display("FAIL rq_reach_8: req=%b addr=%h, expected 1 00000008", imem_req, imem_addr);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect_pc = 32'h0000_0083;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL rq_first_target: req=%b addr=%h, expected 1 00000040", imem_req, imem_addr);
        end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL rq_second_target: req=%b addr=%h, expected 1 00000080", imem_req, imem_addr);
        end
        expect_fetch(32'h0000_0080);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (inst_valid && (pc == 32'h8 || inst == mem_word(32'h8))) seen_8 = 1'b1;
        end
        checks++;
        if (seen_8) begin
            errors++;
            $display("FAIL rq_killed_data: inst_valid raised for 0x8 (seen=%b), expected 0", seen_8);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rq_drain: %0d fetches still expected, expected 0", exp_q.size());
        end
        tick();
        inst_ready = 1'b0;
    endtask

    // stop with ready and redirect: halt, no further requests, stray ack ignored.
    task automatic test_halt();
        int bad = 0;
        do_reset();
        mem_lat    = 0;
        inst_ready = 1'b1;
        expect_fetch(32'h0);
        wait_valid("halt", 10);
        stop        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: halted=%b req=%b valid=%b, expected 1 0 0",
                     halted, imem_req, inst_valid);
        end
        tick();
        stop     = 1'b0;
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stray_ack = (i == 3);
            @(negedge clk);
            if (imem_req || inst_valid || !halted) bad++;
            tick();
        end
        stray_ack = 1'b0;
        checks++;
        if (bad != 0 || inst !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL halt_sticky: %0d bad cycles, inst=%h, expected 0 cycles inst=%h",
                     bad, inst, mem_word(32'h0));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL halt_consume: %0d fetches not consumed, expected 0", exp_q.size());
        end
    endtask

    // RESET_PC at the top of memory: second fetch wraps to zero.
    task automatic test_pc_wrap();
        logic [XLEN-1:0] addrs [2];
        int              cnt = 0;
        addrs[0] = '0;
        addrs[1] = '0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (w_req && cnt < 2) begin
                addrs[cnt] = w_addr;
                cnt++;
            end
        end
        checks++;
        if (cnt != 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: %0d fetches, addrs=%h %h, expected 2 FFFFFFFC 00000000",
                     cnt, addrs[0], addrs[1]);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        stop        = 1'b0;
        stray_ack   = 1'b0;
        test_reset();
        test_sequential();
        test_slow_mem();
        test_redirect_valid();
        test_redirect_taken();
        test_redirect_req();
        test_halt();
        test_pc_wrap();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
